// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter and sequencer for register-to-register moves over the shared bus mux.
// Each move takes three cycles: arbitrate (IDLE), settle (DRIVE), write (WRITE).
//
// state | meaning
// IDLE  | bus parked on IDLE_SRC, choosing the next winner
// DRIVE | source driven onto the bus, grant held, no write yet
// WRITE | destination strobed, done/err pulse, then back to IDLE
module bus_transfer_arbiter #(
  parameter int                NREQ     = 2,
  parameter int                SRC_W    = 4,
  parameter int                DST_W    = 16,
  parameter int                MAX_SRC  = 11,
  parameter logic [SRC_W-1:0]  IDLE_SRC = 4'd12,
  parameter int                MAX_LOCK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*SRC_W-1:0]   src,
  input  logic [NREQ*DST_W-1:0]   dst,
  output logic [SRC_W-1:0]        read_en,
  output logic [DST_W-1:0]        write_en,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    err,
  output logic                    busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0]    MAX_LOCK_C = CW'(MAX_LOCK);
  localparam logic [SRC_W-1:0] MAX_SRC_C  = SRC_W'(MAX_SRC);

  typedef enum logic [1:0] {IDLE, DRIVE, WRITE} state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [CW-1:0]     lock_cnt;
  logic [DST_W-1:0]  cap_dst;
  logic              cap_valid;

  logic [PW-1:0]     rr_win;
  logic [PW-1:0]     win;
  logic              keep;
  logic [NREQ-1:0]   win_onehot;
  logic [SRC_W-1:0]  win_src;
  logic [DST_W-1:0]  win_dst;
  logic              win_valid;

  // Lock only extends a streak that began with a locked grant, so the first
  // grant after reset always goes through round-robin (req0 first).
  always_comb begin
    int j;
    j       = 0;
    rr_win  = rr_ptr;
    for (int k = NREQ; k >= 1; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) rr_win = PW'(j);
    end
    keep = (lock_cnt != '0) && (lock_cnt < MAX_LOCK_C) && req[rr_ptr] && lock[rr_ptr];
    win  = keep ? rr_ptr : rr_win;

    win_onehot = '0;
    win_src    = '0;
    win_dst    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (PW'(k) == win) begin
        win_onehot[k] = 1'b1;
        win_src       = src[k*SRC_W +: SRC_W];
        win_dst       = dst[k*DST_W +: DST_W];
      end
    end
    win_valid = (win_src <= MAX_SRC_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= PW'(NREQ - 1);
      lock_cnt  <= '0;
      cap_dst   <= '0;
      cap_valid <= 1'b0;
      read_en   <= IDLE_SRC;
      write_en  <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != '0) begin
            state     <= DRIVE;
            rr_ptr    <= win;
            lock_cnt  <= keep ? lock_cnt + 1'b1 : (lock[win] ? CW'(1) : '0);
            cap_dst   <= win_dst;
            cap_valid <= win_valid;
            gnt       <= win_onehot;
            busy      <= 1'b1;
            read_en   <= win_valid ? win_src : IDLE_SRC;
          end
          write_en <= '0;
          done     <= '0;
          err      <= 1'b0;
        end
        DRIVE: begin
          state    <= WRITE;
          write_en <= cap_valid ? cap_dst : '0;
          done     <= gnt;
          err      <= ~cap_valid;
        end
        WRITE: begin
          state    <= IDLE;
          read_en  <= IDLE_SRC;
          write_en <= '0;
          gnt      <= '0;
          done     <= '0;
          err      <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          read_en  <= IDLE_SRC;
          write_en <= '0;
          gnt      <= '0;
          done     <= '0;
          err      <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Bench for bus_transfer_arbiter: directed scenarios followed by randomized moves,
// checked cycle by cycle against a transaction-level arbitration model.
module tb_bus_transfer_arbiter;
  localparam int NREQ = 2;
  localparam int SRC_W = 4;
  localparam int DST_W = 16;
  localparam int MAX_SRC = 11;
  localparam int IDLE_V = 12;
  localparam int MAX_LOCK = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req, lock;
  logic [NREQ*SRC_W-1:0] src;
  logic [NREQ*DST_W-1:0] dst;
  logic [SRC_W-1:0]      read_en;
  logic [DST_W-1:0]      write_en;
  logic [NREQ-1:0]       gnt, done;
  logic                  err, busy;

  int vectors = 0;
  int miscompares = 0;
  int last_win;
  int streak;

  bus_transfer_arbiter #(
    .NREQ(NREQ), .SRC_W(SRC_W), .DST_W(DST_W), .MAX_SRC(MAX_SRC),
    .IDLE_SRC(4'd12), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .src(src), .dst(dst),
    .read_en(read_en), .write_en(write_en), .gnt(gnt), .done(done),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".read_en"}, 32'(read_en), IDLE_V);
    chk({tag, ".gnt"}, 32'(gnt), 0);
    chk({tag, ".write_en"}, 32'(write_en), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".err"}, 32'(err), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
  endtask

  task automatic model_reset();
    last_win = NREQ - 1;
    streak   = 0;
  endtask

  // A requester that won with lock held may keep the bus until it has had
  // MAX_LOCK grants in a row; otherwise the next requester after the last winner wins.
  task automatic model_pick(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, output int g);
    if (streak > 0 && streak < MAX_LOCK && r[last_win] && l[last_win]) begin
      g = last_win;
      streak++;
    end else begin
      g = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (last_win + k) % NREQ;
        if (g < 0 && r[c]) g = c;
      end
      streak = l[g] ? 1 : 0;
    end
    last_win = g;
  endtask

  task automatic xfer(input string tag, input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                      input logic [NREQ*SRC_W-1:0] s, input logic [NREQ*DST_W-1:0] d,
                      input bit scramble);
    int g;
    logic [SRC_W-1:0] sv;
    logic [DST_W-1:0] dv;
    bit valid;
    req = r; lock = l; src = s; dst = d;
    if (r == '0) begin
      @(negedge clk);
      check_idle({tag, ".noreq"});
      return;
    end
    model_pick(r, l, g);
    sv = s[g*SRC_W +: SRC_W];
    dv = d[g*DST_W +: DST_W];
    valid = (int'(sv) <= MAX_SRC);
    @(negedge clk);
    chk({tag, ".drive.gnt"}, 32'(gnt), 32'(1) << g);
    chk({tag, ".drive.busy"}, 32'(busy), 1);
    chk({tag, ".drive.read_en"}, 32'(read_en), valid ? 32'(sv) : IDLE_V);
    chk({tag, ".drive.write_en"}, 32'(write_en), 0);
    chk({tag, ".drive.done"}, 32'(done), 0);
    if (scramble) begin
      src = NREQ*SRC_W'($urandom); dst = $urandom;
      req = NREQ'($urandom); lock = NREQ'($urandom);
    end
    @(negedge clk);
    chk({tag, ".write.gnt"}, 32'(gnt), 32'(1) << g);
    chk({tag, ".write.busy"}, 32'(busy), 1);
    chk({tag, ".write.read_en"}, 32'(read_en), valid ? 32'(sv) : IDLE_V);
    chk({tag, ".write.write_en"}, 32'(write_en), valid ? 32'(dv) : 0);
    chk({tag, ".write.done"}, 32'(done), 32'(1) << g);
    chk({tag, ".write.err"}, 32'(err), valid ? 0 : 1);
    @(negedge clk);
    check_idle({tag, ".after"});
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0; src = '0; dst = '0;
    model_reset();
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    xfer("t2_single", 2'b01, 2'b00, {4'd0, 4'd5}, {16'h0, 16'h0004}, 1'b0);
    for (int i = 0; i < 4; i++)
      xfer("t3_rr", 2'b11, 2'b00, {4'd3, 4'd7}, {16'h0100, 16'h0010}, 1'b0);
    for (int i = 0; i < 6; i++)
      xfer("t4_lock", 2'b11, 2'b01, {4'd2, 4'd9}, {16'h0002, 16'h8000}, 1'b0);
    xfer("t5_badsrc", 2'b10, 2'b00, {4'd13, 4'd1}, {16'h00FF, 16'h0001}, 1'b0);
    xfer("dst_zero", 2'b01, 2'b00, {4'd0, 4'd11}, {16'h0, 16'h0}, 1'b0);

    // Reset mid-DRIVE: outputs clear immediately and the move is dropped.
    req = 2'b01; lock = 2'b00; src = {4'd4, 4'd6}; dst = {16'h0, 16'h0040};
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle("t6_reset_drive");
    @(negedge clk);
    check_idle("t6_reset_held");
    rst = 1'b0;
    model_reset();
    xfer("t6_regrant", 2'b01, 2'b00, {4'd4, 4'd6}, {16'h0, 16'h0040}, 1'b0);

    for (int i = 0; i < 200; i++)
      xfer("rand", NREQ'($urandom), NREQ'($urandom), NREQ*SRC_W'($urandom), $urandom, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
